// File: rtl/sprite_loader_pkg.sv
// rtl/sprite_loader_pkg.sv - shared state encodings and command bytes for the sprite loader
package sprite_loader_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_PAL  = 2'd1;
    localparam state_t ST_IMG  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    localparam logic [7:0] CMD_PAL  = 8'hA5;
    localparam logic [7:0] CMD_IMG0 = 8'h5A;
    localparam logic [7:0] CMD_IMG1 = 8'h5B;

    localparam int PAL_ENTRIES = 256;

endpackage

// File: rtl/sprite_loader.sv
// rtl/sprite_loader.sv - byte-stream loader filling sprite image and palette BRAM write ports
module sprite_loader
    import sprite_loader_pkg::*;
#(
    parameter int WIDTH   = 256,
    parameter int HEIGHT  = 256,
    parameter int TIMEOUT = 1000000,
    localparam int AW     = $clog2(WIDTH * HEIGHT * 2)
) (
    input  logic          pixel_clk_in,
    input  logic          rst_in,
    input  logic [7:0]    byte_in,
    input  logic          byte_valid_in,
    output logic          byte_ready_out,
    input  logic          abort_in,
    output logic          img_we_out,
    output logic [AW-1:0] img_addr_out,
    output logic [7:0]    img_data_out,
    output logic          pal_we_out,
    output logic [7:0]    pal_addr_out,
    output logic [23:0]   pal_data_out,
    output logic          busy_out,
    output logic          done_out,
    output logic          err_out
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [AW-1:0] FRAME1_BASE = AW'(WIDTH * HEIGHT);
    localparam logic [AW-1:0] IMG_LAST    = AW'(WIDTH * HEIGHT - 1);
    localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT - 1);
    localparam logic [7:0]    PAL_LAST    = 8'(PAL_ENTRIES - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          frame_q, frame_d;
    logic [1:0]    phase_q, phase_d;
    logic [7:0]    entry_q, entry_d;
    logic [15:0]   rg_q, rg_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          img_we_q, img_we_d;
    logic [AW-1:0] img_addr_q, img_addr_d;
    logic [7:0]    img_data_q, img_data_d;
    logic          pal_we_q, pal_we_d;
    logic [7:0]    pal_addr_q, pal_addr_d;
    logic [23:0]   pal_data_q, pal_data_d;
    logic          err_q, err_d;
    logic          xfer;
    logic [AW-1:0] img_base;

    // Abort gates ready combinationally so the byte offered that cycle stays with the source.
    assign byte_ready_out = (state_q != ST_DONE) && !abort_in;
    assign xfer           = byte_valid_in && byte_ready_out;
    assign img_base       = frame_q ? FRAME1_BASE : '0;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        frame_d    = frame_q;
        phase_d    = phase_q;
        entry_d    = entry_q;
        rg_d       = rg_q;
        to_cnt_d   = to_cnt_q;
        img_we_d   = 1'b0;
        img_addr_d = img_addr_q;
        img_data_d = img_data_q;
        pal_we_d   = 1'b0;
        pal_addr_d = pal_addr_q;
        pal_data_d = pal_data_q;
        err_d      = 1'b0;

        if (abort_in) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            phase_d  = '0;
            entry_d  = '0;
            to_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (xfer) begin
                        cnt_d    = '0;
                        phase_d  = '0;
                        entry_d  = '0;
                        to_cnt_d = '0;
                        case (byte_in)
                            CMD_PAL:  state_d = ST_PAL;
                            CMD_IMG0: begin state_d = ST_IMG; frame_d = 1'b0; end
                            CMD_IMG1: begin state_d = ST_IMG; frame_d = 1'b1; end
                            default:  err_d = 1'b1;
                        endcase
                    end
                end
                ST_PAL: begin
                    if (xfer) begin
                        to_cnt_d = '0;
                        rg_d     = {rg_q[7:0], byte_in};
                        if (phase_q == 2'd2) begin
                            phase_d    = '0;
                            pal_we_d   = 1'b1;
                            pal_addr_d = entry_q;
                            pal_data_d = {rg_q, byte_in};
                            if (entry_q == PAL_LAST) state_d = ST_DONE;
                            else                     entry_d = entry_q + 8'd1;
                        end else begin
                            phase_d = phase_q + 2'd1;
                        end
                    end else if (to_cnt_q == TO_LAST) begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
                ST_IMG: begin
                    if (xfer) begin
                        to_cnt_d   = '0;
                        img_we_d   = 1'b1;
                        img_addr_d = img_base + cnt_q;
                        img_data_d = byte_in;
                        if (cnt_q == IMG_LAST) state_d = ST_DONE;
                        else                   cnt_d   = cnt_q + 1'b1;
                    end else if (to_cnt_q == TO_LAST) begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            frame_q    <= 1'b0;
            phase_q    <= '0;
            entry_q    <= '0;
            rg_q       <= '0;
            to_cnt_q   <= '0;
            img_we_q   <= 1'b0;
            img_addr_q <= '0;
            img_data_q <= '0;
            pal_we_q   <= 1'b0;
            pal_addr_q <= '0;
            pal_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            frame_q    <= frame_d;
            phase_q    <= phase_d;
            entry_q    <= entry_d;
            rg_q       <= rg_d;
            to_cnt_q   <= to_cnt_d;
            img_we_q   <= img_we_d;
            img_addr_q <= img_addr_d;
            img_data_q <= img_data_d;
            pal_we_q   <= pal_we_d;
            pal_addr_q <= pal_addr_d;
            pal_data_q <= pal_data_d;
            err_q      <= err_d;
        end
    end

    assign img_we_out   = img_we_q;
    assign img_addr_out = img_addr_q;
    assign img_data_out = img_data_q;
    assign pal_we_out   = pal_we_q;
    assign pal_addr_out = pal_addr_q;
    assign pal_data_out = pal_data_q;
    assign busy_out     = (state_q != ST_IDLE);
    assign done_out     = (state_q == ST_DONE);
    assign err_out      = err_q;

endmodule

// File: tb/tb_sprite_loader.sv
// tb/tb_sprite_loader.sv - scoreboard and vector-table bench for sprite_loader
module tb_sprite_loader;

    localparam int WIDTH   = 256;
    localparam int HEIGHT  = 256;
    localparam int TIMEOUT = 50;
    localparam int AW      = $clog2(WIDTH * HEIGHT * 2);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    byte_i = 8'h00;
    logic          valid = 1'b0;
    logic          ready;
    logic          abort = 1'b0;
    logic          img_we;
    logic [AW-1:0] img_addr;
    logic [7:0]    img_data;
    logic          pal_we;
    logic [7:0]    pal_addr;
    logic [23:0]   pal_data;
    logic          busy, done, err;

    sprite_loader #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .TIMEOUT(TIMEOUT)) dut (
        .pixel_clk_in  (clk),
        .rst_in        (rst),
        .byte_in       (byte_i),
        .byte_valid_in (valid),
        .byte_ready_out(ready),
        .abort_in      (abort),
        .img_we_out    (img_we),
        .img_addr_out  (img_addr),
        .img_data_out  (img_data),
        .pal_we_out    (pal_we),
        .pal_addr_out  (pal_addr),
        .pal_data_out  (pal_data),
        .busy_out      (busy),
        .done_out      (done),
        .err_out       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [23:0]   data;
    } wr_t;

    typedef struct {
        logic [7:0] cmd;
        logic       exp_err;
        logic       exp_busy;
    } vec_t;

    wr_t pal_q[$];
    wr_t img_q[$];
    wr_t pe, ie;

    int cmp_cnt = 0;
    int bad_cnt = 0;
    int done_cnt = 0;
    int pal_wr_cnt = 0;
    int img_wr_cnt = 0;
    logic [23:0]   pal3_data = '0;
    bit            img_first_seen = 0;
    logic [AW-1:0] img_first_addr = '0, img_last_addr = '0;
    logic [7:0]    img_first_data = '0, img_last_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: each write strobe pops the oldest expected write of its kind.
    always @(negedge clk) begin
        if (pal_we === 1'b1) begin
            pal_wr_cnt++;
            check("pal_write_expected", 32'(pal_q.size() > 0), 32'd1);
            if (pal_q.size() > 0) begin
                pe = pal_q.pop_front();
                check("pal_addr", 32'(pal_addr), 32'(pe.addr));
                check("pal_data", 32'(pal_data), 32'(pe.data));
            end
            if (pal_addr == 8'd3) pal3_data = pal_data;
        end
        if (img_we === 1'b1) begin
            img_wr_cnt++;
            check("img_write_expected", 32'(img_q.size() > 0), 32'd1);
            if (img_q.size() > 0) begin
                ie = img_q.pop_front();
                check("img_addr", 32'(img_addr), 32'(ie.addr));
                check("img_data", 32'(img_data), 32'(ie.data[7:0]));
            end
            if (!img_first_seen) begin
                img_first_seen = 1;
                img_first_addr = img_addr;
                img_first_data = img_data;
            end
            img_last_addr = img_addr;
            img_last_data = img_data;
        end
        if (done === 1'b1) begin
            done_cnt++;
            check("done_with_final_strobe", 32'(pal_we | img_we), 32'd1);
        end
    end

    task automatic send(input logic [7:0] b);
        bit acc = 0;
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge clk);
            byte_i = b;
            valid  = 1'b1;
            #1;
            acc = ready;
            @(posedge clk);
        end
        if (!acc) check("send_accept", 32'(acc), 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid = 1'b0;
            @(posedge clk);
        end
    endtask

    task automatic load_palette(input bit gaps, input string tag);
        int d0 = done_cnt;
        logic [7:0] nb;
        send(8'hA5);
        for (int n = 0; n < 256; n++) begin
            nb = 8'(n);
            pal_q.push_back('{addr: AW'(n), data: {nb, ~nb, 8'h55}});
            if (gaps) idle($urandom_range(0, 2));
            send(nb);
            if (gaps) idle($urandom_range(0, 2));
            send(~nb);
            if (gaps) idle($urandom_range(0, 2));
            send(8'h55);
        end
        idle(3);
        check({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_queue_drained"}, 32'(pal_q.size()), 32'd0);
    endtask

    vec_t vecs[6];
    int   found;
    int   p0, i0;

    initial begin
        vecs[0] = '{cmd: 8'h00, exp_err: 1'b1, exp_busy: 1'b0};
        vecs[1] = '{cmd: 8'hFF, exp_err: 1'b1, exp_busy: 1'b0};
        vecs[2] = '{cmd: 8'hA4, exp_err: 1'b1, exp_busy: 1'b0};
        vecs[3] = '{cmd: 8'hA5, exp_err: 1'b0, exp_busy: 1'b1};
        vecs[4] = '{cmd: 8'h5A, exp_err: 1'b0, exp_busy: 1'b1};
        vecs[5] = '{cmd: 8'h5B, exp_err: 1'b0, exp_busy: 1'b1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_pal_we", 32'(pal_we), 32'd0);
        check("rst_img_we", 32'(img_we), 32'd0);
        rst = 1'b0;

        // Command decode table; valid commands are aborted straight away.
        for (int v = 0; v < 6; v++) begin
            send(vecs[v].cmd);
            #1;
            check("tbl_err", 32'(err), 32'(vecs[v].exp_err));
            check("tbl_busy", 32'(busy), 32'(vecs[v].exp_busy));
            @(negedge clk);
            valid = 1'b0;
            abort = vecs[v].exp_busy;
            @(posedge clk);
            #1;
            check("tbl_busy_after", 32'(busy), 32'd0);
            check("tbl_err_single_pulse", 32'(err), 32'd0);
            @(negedge clk);
            abort = 1'b0;
        end

        load_palette(0, "pal_gapless");
        check("pal_entry3", 32'(pal3_data), 32'h0003FC55);
        load_palette(1, "pal_gaps");

        img_first_seen = 0;
        p0 = pal_wr_cnt;
        send(8'h5B);
        for (int k = 0; k < WIDTH * HEIGHT; k++) begin
            img_q.push_back('{addr: AW'(WIDTH * HEIGHT + k), data: 24'(k % 256)});
            send(8'(k % 256));
        end
        idle(3);
        check("img1_first_addr", 32'(img_first_addr), 32'd65536);
        check("img1_first_data", 32'(img_first_data), 32'd0);
        check("img1_last_addr", 32'(img_last_addr), 32'd131071);
        check("img1_last_data", 32'(img_last_data), 32'd255);
        check("img1_no_pal_we", 32'(pal_wr_cnt - p0), 32'd0);
        check("img1_busy_after", 32'(busy), 32'd0);

        i0 = img_wr_cnt;
        send(8'h5A);
        for (int k = 0; k < 10; k++) begin
            img_q.push_back('{addr: AW'(k), data: 24'(8'h30 + k)});
            send(8'(8'h30 + k));
        end
        @(negedge clk);
        valid = 1'b0;
        found = 0;
        for (int i = 1; i <= 80 && found == 0; i++) begin
            @(posedge clk);
            #1;
            if (err === 1'b1) found = i;
        end
        check("timeout_cycles", 32'(found), 32'(TIMEOUT));
        check("timeout_writes", 32'(img_wr_cnt - i0), 32'd10);
        check("timeout_busy", 32'(busy), 32'd0);

        // Abort with a byte offered: byte refused, pending write still lands.
        idle(2);
        send(8'h5A);
        for (int k = 0; k < 3; k++) begin
            img_q.push_back('{addr: AW'(k), data: 24'(8'hC0 + k)});
            send(8'(8'hC0 + k));
        end
        @(negedge clk);
        abort  = 1'b1;
        byte_i = 8'hEE;
        valid  = 1'b1;
        #1;
        check("abort_ready_low", 32'(ready), 32'd0);
        @(posedge clk);
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_no_err", 32'(err), 32'd0);
        @(negedge clk);
        abort = 1'b0;
        valid = 1'b0;
        idle(2);
        check("abort_img_drained", 32'(img_q.size()), 32'd0);

        p0 = pal_wr_cnt;
        send(8'hA5);
        pal_q.push_back('{addr: AW'(0), data: 24'h112233});
        send(8'h11);
        send(8'h22);
        send(8'h33);
        send(8'h44);
        send(8'h55);
        @(negedge clk);
        byte_i = 8'h66;
        valid  = 1'b1;
        rst    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst   = 1'b0;
        valid = 1'b0;
        check("rst_mid_pal_we", 32'(pal_we), 32'd0);
        idle(3);
        check("rst_mid_pal_writes", 32'(pal_wr_cnt - p0), 32'd1);
        check("rst_mid_pal_busy", 32'(busy), 32'd0);

        check("final_pal_q", 32'(pal_q.size()), 32'd0);
        check("final_img_q", 32'(img_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, bad_cnt);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
